// File: rtl/case_5_prod_accum.sv
// rtl/case_5_prod_accum.sv - framed signed product accumulator with hold-until-accepted output
//
// Sums LEN signed products per frame and presents the frame sum with a
// valid/ready handshake. A sum is held on acc_dout until the consumer
// takes it; a product offered on that same cycle opens the next frame.
//
// Parameters:
//   din_WIDTH  signed product width
//   acc_WIDTH  signed accumulator / output width (din_WIDTH+1..32)
//   LEN        products per frame (1..256)
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst     synchronous active-high reset
//   prod_din   signed product in
//   prod_vld   prod_din valid
//   prod_rdy   block accepts prod_din
//   acc_dout   signed frame sum
//   acc_vld    acc_dout valid
//   acc_rdy    downstream accepts acc_dout
//   acc_ovf    frame overflow flag, qualified by acc_vld
//
// Build option:
//   CASE_5_PROD_ACCUM_SAT_EN  defined: overflowing additions clamp to the
//                             signed range; undefined: sums wrap.

module case_5_prod_accum #(
    parameter int din_WIDTH = 12,
    parameter int acc_WIDTH = 16,
    parameter int LEN       = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [din_WIDTH-1:0] prod_din,
    input  logic                 prod_vld,
    output logic                 prod_rdy,
    output logic [acc_WIDTH-1:0] acc_dout,
    output logic                 acc_vld,
    input  logic                 acc_rdy,
    output logic                 acc_ovf
);

    // Counter only ever holds 0..LEN-1.
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [acc_WIDTH-1:0] ACC_MAX = {1'b0, {(acc_WIDTH-1){1'b1}}};
    localparam logic [acc_WIDTH-1:0] ACC_MIN = {1'b1, {(acc_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [acc_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 ovf_run;

    logic                 accept;
    logic                 last;
    logic [acc_WIDTH:0]   sum_ext;
    logic                 add_ovf;
    logic [acc_WIDTH-1:0] sum;
    logic                 sum_ovf;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prod_rdy  = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ACCUM:   prod_rdy = !ap_rst;
            HOLD:    prod_rdy = acc_rdy && !ap_rst;
            default: prod_rdy = 1'b0;
        endcase
        accept = prod_vld && prod_rdy;
        // cnt is always 0 in HOLD, so a HOLD acceptance is sample 1 and is
        // only the last sample when LEN is 1.
        last   = accept && (cnt == CNT_LAST);
        case (state)
            ACCUM: begin
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (acc_rdy && !last) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // acc and ovf_run are cleared when a frame closes, so the next frame
    // always starts from zero without a separate load path.
    always_comb begin
        sum_ext = {acc[acc_WIDTH-1], acc}
                + {{(acc_WIDTH + 1 - din_WIDTH){prod_din[din_WIDTH-1]}}, prod_din};
        add_ovf = sum_ext[acc_WIDTH] ^ sum_ext[acc_WIDTH-1];
`ifdef CASE_5_PROD_ACCUM_SAT_EN
        if (add_ovf) begin
            sum = sum_ext[acc_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = sum_ext[acc_WIDTH-1:0];
        end
`else
        sum = sum_ext[acc_WIDTH-1:0];
`endif
        sum_ovf = ovf_run | add_ovf;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovf_run  <= 1'b0;
            acc_dout <= '0;
            acc_ovf  <= 1'b0;
        end else if (accept) begin
            if (last) begin
                acc      <= '0;
                cnt      <= '0;
                ovf_run  <= 1'b0;
                acc_dout <= sum;
                acc_ovf  <= sum_ovf;
            end else begin
                acc      <= sum;
                cnt      <= cnt + CW'(1);
                ovf_run  <= sum_ovf;
            end
        end else if (state == HOLD && acc_rdy) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_run <= 1'b0;
        end
    end

    assign acc_vld = (state == HOLD);

endmodule

// File: tb/tb_case_5_prod_accum.sv
// tb/tb_case_5_prod_accum.sv - directed self-checking bench for case_5_prod_accum
module tb_case_5_prod_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        ap_rst;
    logic [11:0] prod_din;
    logic        prod_vld;
    logic        acc_rdy;

    logic        rdy16, vld16, ovf16;
    logic [15:0] dout16;
    logic        rdy14, vld14, ovf14;
    logic [13:0] dout14;
    logic        rdy1, vld1, ovf1;
    logic [15:0] dout1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CASE_5_PROD_ACCUM_SAT_EN
    localparam logic [13:0] EXP14 = 14'h1FFF;
`else
    localparam logic [13:0] EXP14 = 14'h3FF8;
`endif

    case_5_prod_accum #(.din_WIDTH(12), .acc_WIDTH(16), .LEN(16)) dut (
        .ap_clk(clk), .ap_rst(ap_rst), .prod_din(prod_din), .prod_vld(prod_vld),
        .prod_rdy(rdy16), .acc_dout(dout16), .acc_vld(vld16), .acc_rdy(acc_rdy),
        .acc_ovf(ovf16)
    );

    case_5_prod_accum #(.din_WIDTH(12), .acc_WIDTH(14), .LEN(8)) dut14 (
        .ap_clk(clk), .ap_rst(ap_rst), .prod_din(prod_din), .prod_vld(prod_vld),
        .prod_rdy(rdy14), .acc_dout(dout14), .acc_vld(vld14), .acc_rdy(acc_rdy),
        .acc_ovf(ovf14)
    );

    case_5_prod_accum #(.din_WIDTH(12), .acc_WIDTH(16), .LEN(1)) dut1 (
        .ap_clk(clk), .ap_rst(ap_rst), .prod_din(prod_din), .prod_vld(prod_vld),
        .prod_rdy(rdy1), .acc_dout(dout1), .acc_vld(vld1), .acc_rdy(acc_rdy),
        .acc_ovf(ovf1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ap_rst   = 1'b1;
        prod_vld = 1'b0;
        acc_rdy  = 1'b0;
        prod_din = '0;
        tick;
        tick;
        ap_rst = 1'b0;
    endtask

    task automatic feed(input logic [11:0] d, input int n);
        prod_din = d;
        prod_vld = 1'b1;
        repeat (n) tick;
        prod_vld = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst = 1'b1; prod_vld = 1'b0; acc_rdy = 1'b0; prod_din = '0;
        tick;
        tick;
        n_checks++; if (rdy16 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", rdy16); end
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld16); end
        n_checks++; if (dout16 !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", dout16); end
        n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf16); end
        ap_rst = 1'b0;
        #1;
        n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL post_reset_rdy: got %b expected 1", rdy16); end
    endtask

    task automatic test_plus3;
        do_reset;
        feed(12'd3, 15);
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL plus3_early_vld: got %b expected 0", vld16); end
        feed(12'd3, 1);
        n_checks++; if (vld16 !== 1'b1) begin n_fail++; $display("FAIL plus3_vld: got %b expected 1", vld16); end
        n_checks++; if (dout16 !== 16'd48) begin n_fail++; $display("FAIL plus3_dout: got %0d expected 48", dout16); end
        n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL plus3_ovf: got %b expected 0", ovf16); end
    endtask

    task automatic test_hold;
        prod_din = 12'd7;
        prod_vld = 1'b1;
        repeat (5) begin
            tick;
            n_checks++; if (dout16 !== 16'd48 || vld16 !== 1'b1 || rdy16 !== 1'b0) begin
                n_fail++; $display("FAIL hold_stable: got dout=%0d vld=%b rdy=%b expected 48 1 0", dout16, vld16, rdy16);
            end
        end
        acc_rdy = 1'b1;
        #1;
        n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL hold_rdy_follow: got %b expected 1", rdy16); end
        tick;
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL hold_release_vld: got %b expected 0", vld16); end
        feed(12'd0, 14);
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL hold_next_early: got %b expected 0", vld16); end
        feed(12'd0, 1);
        n_checks++; if (vld16 !== 1'b1 || dout16 !== 16'd7) begin
            n_fail++; $display("FAIL hold_next_sum: got vld=%b dout=%0d expected 1 7", vld16, dout16);
        end
        acc_rdy = 1'b0;
    endtask

    task automatic test_min;
        do_reset;
        feed(12'h800, 16);
        n_checks++; if (vld16 !== 1'b1 || dout16 !== 16'h8000) begin
            n_fail++; $display("FAIL min_dout: got vld=%b dout=%h expected 1 8000", vld16, dout16);
        end
        n_checks++; if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL min_ovf: got %b expected 0", ovf16); end
    endtask

    task automatic test_max;
        do_reset;
        feed(12'd2047, 16);
        n_checks++; if (dout16 !== 16'd32752 || ovf16 !== 1'b0) begin
            n_fail++; $display("FAIL max_frame1: got dout=%0d ovf=%b expected 32752 0", dout16, ovf16);
        end
        acc_rdy = 1'b1;
        feed(12'd2047, 16);
        n_checks++; if (vld16 !== 1'b1 || dout16 !== 16'd32752 || ovf16 !== 1'b0) begin
            n_fail++; $display("FAIL max_frame2: got vld=%b dout=%0d ovf=%b expected 1 32752 0", vld16, dout16, ovf16);
        end
        feed(12'd100, 1);
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL max_extra_vld: got %b expected 0", vld16); end
        feed(12'd0, 15);
        n_checks++; if (vld16 !== 1'b1 || dout16 !== 16'd100) begin
            n_fail++; $display("FAIL max_extra_sum: got vld=%b dout=%0d expected 1 100", vld16, dout16);
        end
        acc_rdy = 1'b0;
    endtask

    task automatic test_ovf14;
        do_reset;
        feed(12'd2047, 8);
        n_checks++; if (vld14 !== 1'b1 || dout14 !== EXP14) begin
            n_fail++; $display("FAIL ovf14_dout: got vld=%b dout=%h expected 1 %h", vld14, dout14, EXP14);
        end
        n_checks++; if (ovf14 !== 1'b1) begin n_fail++; $display("FAIL ovf14_flag: got %b expected 1", ovf14); end
        acc_rdy = 1'b1;
        feed(12'd1, 8);
        n_checks++; if (vld14 !== 1'b1 || dout14 !== 14'd8 || ovf14 !== 1'b0) begin
            n_fail++; $display("FAIL ovf14_clear: got vld=%b dout=%0d ovf=%b expected 1 8 0", vld14, dout14, ovf14);
        end
        acc_rdy = 1'b0;
    endtask

    task automatic test_mid_reset;
        do_reset;
        acc_rdy = 1'b1;
        feed(12'd5, 9);
        ap_rst = 1'b1;
        tick;
        ap_rst = 1'b0;
        n_checks++; if (vld16 !== 1'b0 || dout16 !== 16'd0) begin
            n_fail++; $display("FAIL midrst_state: got vld=%b dout=%0d expected 0 0", vld16, dout16);
        end
        feed(12'd1, 15);
        n_checks++; if (vld16 !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b expected 0", vld16); end
        feed(12'd1, 1);
        n_checks++; if (vld16 !== 1'b1 || dout16 !== 16'd16) begin
            n_fail++; $display("FAIL midrst_sum: got vld=%b dout=%0d expected 1 16", vld16, dout16);
        end
        acc_rdy = 1'b0;
    endtask

    task automatic test_len1;
        do_reset;
        acc_rdy  = 1'b1;
        prod_vld = 1'b1;
        prod_din = 12'd5;
        tick;
        n_checks++; if (vld1 !== 1'b1 || dout1 !== 16'd5) begin
            n_fail++; $display("FAIL len1_a: got vld=%b dout=%h expected 1 0005", vld1, dout1);
        end
        prod_din = 12'hFFA;
        tick;
        n_checks++; if (vld1 !== 1'b1 || dout1 !== 16'hFFFA) begin
            n_fail++; $display("FAIL len1_b: got vld=%b dout=%h expected 1 fffa", vld1, dout1);
        end
        prod_din = 12'd7;
        tick;
        n_checks++; if (vld1 !== 1'b1 || dout1 !== 16'd7) begin
            n_fail++; $display("FAIL len1_c: got vld=%b dout=%h expected 1 0007", vld1, dout1);
        end
        prod_vld = 1'b0;
        tick;
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL len1_drain: got %b expected 0", vld1); end
        acc_rdy = 1'b0;
    endtask

    initial begin
        ap_rst   = 1'b1;
        prod_vld = 1'b0;
        acc_rdy  = 1'b0;
        prod_din = '0;
        test_reset;
        test_plus3;
        test_hold;
        test_min;
        test_max;
        test_ovf14;
        test_mid_reset;
        test_len1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
